// File: rtl/proc_req_driver_pkg.sv
// Shared types for the processor-side cache request driver:
// default bus widths, FSM state encoding and the queued command record.
package proc_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/proc_req_driver_if.sv
// Command, cache-access and response signals of proc_req_driver.
// The master side is the driver; the slave side is the core/cache environment.
interface proc_req_driver_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              PrRd;
    logic              PrWr;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic [DATA_W-1:0] data_in;
    logic              bus_done;
    logic              rsp_valid;
    logic              rsp_wr;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_timeout;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, data_in, bus_done,
        output cmd_ready, PrRd, PrWr, Addr, data_out, data_oe,
               rsp_valid, rsp_wr, rsp_addr, rsp_data, rsp_timeout, busy
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, data_in, bus_done,
        input  cmd_ready, PrRd, PrWr, Addr, data_out, data_oe,
               rsp_valid, rsp_wr, rsp_addr, rsp_data, rsp_timeout, busy
    );

endinterface

// File: rtl/proc_req_driver_req_fifo.sv
// Synchronous command FIFO; full/empty derived from an extra pointer wrap bit.
// A push while full is dropped even if a pop happens on the same edge.
module req_fifo
    import proc_bus_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  cmd_t i_data,
    output logic o_full,
    input  logic i_pop,
    output cmd_t o_data,
    output logic o_empty
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);

    cmd_t           r_mem [QDEPTH];
    logic [PTR_W:0] r_wptr;
    logic [PTR_W:0] r_rptr;
    logic           w_full;
    logic           w_empty;
    logic           w_do_push;
    logic           w_do_pop;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[PTR_W-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/proc_req_driver.sv
// Processor-side PrRd/PrWr initiator: queues commands, issues them one at a
// time to the cache and returns exactly one in-order response per command.
module proc_req_driver
    import proc_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    proc_req_driver_if.master  bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    cmd_t              r_cmd;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_timeout;

    cmd_t              w_push_data;
    cmd_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_done;
    logic              w_tmo;
    logic              w_prrd;
    logic              w_prwr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_dout;
    logic              w_rsp_valid;

    assign w_ready     = !w_full && !rst;
    assign w_push      = bus.cmd_valid && w_ready;
    assign w_push_data = '{wr: bus.cmd_wr, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

    req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cmd         <= '0;
            r_cnt         <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_cmd <= w_head;
                r_cnt <= '0;
            end
            if (r_state == ACCESS) r_cnt <= r_cnt + 1'b1;
            // bus_done takes priority over a timeout on the same edge
            if (w_done) begin
                r_rsp_data    <= r_cmd.wr ? r_cmd.wdata : bus.data_in;
                r_rsp_timeout <= 1'b0;
            end else if (w_tmo) begin
                r_rsp_data    <= '0;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_prrd      = 1'b0;
        w_prwr      = 1'b0;
        w_addr      = '0;
        w_dout      = '0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_prrd = !r_cmd.wr;
                w_prwr = r_cmd.wr;
                w_addr = r_cmd.addr;
                w_dout = r_cmd.wr ? r_cmd.wdata : '0;
                if (bus.bus_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.cmd_ready   = w_ready;
    assign bus.PrRd        = w_prrd;
    assign bus.PrWr        = w_prwr;
    assign bus.Addr        = w_addr;
    assign bus.data_out    = w_dout;
    assign bus.data_oe     = w_prwr;
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.rsp_wr      = w_rsp_valid && r_cmd.wr;
    assign bus.rsp_addr    = w_rsp_valid ? r_cmd.addr : '0;
    assign bus.rsp_data    = w_rsp_valid ? r_rsp_data : '0;
    assign bus.rsp_timeout = w_rsp_valid && r_rsp_timeout;
    assign bus.busy        = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_proc_req_driver.sv
// Scoreboard bench for proc_req_driver with a behavioural cache model whose
// bus_done latency is set per test (0 = never completes).
module tb_proc_req_driver;
    import proc_bus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_req_driver_if #(.ADDR_W(5), .DATA_W(8)) bif ();

    proc_req_driver #(
        .ADDR_W  (5),
        .DATA_W  (8),
        .QDEPTH  (4),
        .TIMEOUT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
        logic       tmo;
        int         len;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         rsp_cyc = 0;
    int         done_at = 1;
    bit         spur = 1'b0;
    int         acc_cnt = 0;
    int         last_len = 0;
    logic [7:0] mem [32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cache model and response monitor share one process so access length is
    // settled before the response that follows it is checked.
    always @(negedge clk) begin
        if (bif.PrRd || bif.PrWr) begin
            acc_cnt++;
            chk("rd_wr_exclusive", 32'(bif.PrRd && bif.PrWr), 0);
            chk("data_oe_eq_prwr", 32'(bif.data_oe), 32'(bif.PrWr));
            if (done_at != 0 && acc_cnt == done_at) begin
                bif.bus_done = 1'b1;
                bif.data_in  = bif.PrRd ? mem[bif.Addr] : 8'h5A;
                if (bif.PrWr) mem[bif.Addr] = bif.data_out;
            end else begin
                bif.bus_done = 1'b0;
                bif.data_in  = 8'h5A;
            end
        end else begin
            if (acc_cnt != 0) last_len = acc_cnt;
            acc_cnt      = 0;
            bif.bus_done = spur;
            bif.data_in  = 8'h5A;
        end
        if (bif.rsp_valid) begin
            rsp_cyc = cyc;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp addr %0h, expected none", bif.rsp_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_wr", 32'(bif.rsp_wr), 32'(mon_e.wr));
                chk("rsp_addr", 32'(bif.rsp_addr), 32'(mon_e.addr));
                chk("rsp_data", 32'(bif.rsp_data), 32'(mon_e.data));
                chk("rsp_timeout", 32'(bif.rsp_timeout), 32'(mon_e.tmo));
                if (mon_e.len != 0) chk("access_len", 32'(last_len), 32'(mon_e.len));
            end
        end
    end

    task automatic send(input logic wr, input logic [4:0] a, input logic [7:0] d,
                        input bit track, input logic [7:0] ed, input logic et, input int elen);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        bif.cmd_valid = 1'b1;
        bif.cmd_wr    = wr;
        bif.cmd_addr  = a;
        bif.cmd_wdata = d;
        while (!bif.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bif.cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL send_accept: cmd_ready 0 after 100 cycles, expected 1");
            bif.cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        if (track) begin
            e.wr = wr; e.addr = a; e.data = ed; e.tmo = et; e.len = elen;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bif.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bif.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_sb_empty", 32'(sb.size()), 0);
        chk("drain_idle", 32'(bif.busy), 0);
    endtask

    int a5;

    initial begin
        bif.cmd_valid = 1'b0;
        bif.cmd_wr    = 1'b0;
        bif.cmd_addr  = '0;
        bif.cmd_wdata = '0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[5'h03] = 8'hA5;
        mem[5'h08] = 8'h11;
        mem[5'h0A] = 8'h22;
        mem[5'h0C] = 8'h33;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bif.cmd_ready), 0);
        chk("rst_prrd", 32'(bif.PrRd), 0);
        chk("rst_prwr", 32'(bif.PrWr), 0);
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("rst_busy", 32'(bif.busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bif.cmd_ready), 1);

        // single read, minimum latency
        done_at = 1;
        send(1'b0, 5'h03, 8'h00, 1'b1, 8'hA5, 1'b0, 1);
        drain();
        chk("read_latency", 32'(rsp_cyc - acc_cyc), 3);

        // write then read same line
        send(1'b1, 5'h1F, 8'h3C, 1'b1, 8'h3C, 1'b0, 1);
        send(1'b0, 5'h1F, 8'h00, 1'b1, 8'h3C, 1'b0, 1);
        drain();

        // fill with stalled cache; bus_done toggled high outside accesses
        done_at = 3;
        spur    = 1'b1;
        send(1'b0, 5'h08, 8'h00, 1'b1, 8'h11, 1'b0, 3);
        send(1'b1, 5'h09, 8'h91, 1'b1, 8'h91, 1'b0, 3);
        send(1'b0, 5'h0A, 8'h00, 1'b1, 8'h22, 1'b0, 3);
        send(1'b1, 5'h0B, 8'hB3, 1'b1, 8'hB3, 1'b0, 3);
        send(1'b0, 5'h0C, 8'h00, 1'b1, 8'h33, 1'b0, 3);
        a5 = acc_cyc;
        @(negedge clk);
        chk("fill_full_ready", 32'(bif.cmd_ready), 0);
        send(1'b1, 5'h0D, 8'hD5, 1'b1, 8'hD5, 1'b0, 3);
        chk("fill_waited", 32'((acc_cyc - a5) > 1), 1);
        drain();
        spur = 1'b0;

        // timeout then normal command
        done_at = 0;
        send(1'b0, 5'h04, 8'h00, 1'b1, 8'h00, 1'b1, 15);
        drain();
        done_at = 1;
        send(1'b0, 5'h03, 8'h00, 1'b1, 8'hA5, 1'b0, 1);
        drain();

        // bus_done in the last allowed ACCESS cycle wins over timeout
        done_at = 15;
        send(1'b0, 5'h03, 8'h00, 1'b1, 8'hA5, 1'b0, 15);
        drain();

        // reset during an access with two commands queued
        done_at = 0;
        send(1'b0, 5'h05, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        send(1'b1, 5'h06, 8'h66, 1'b0, 8'h00, 1'b0, 0);
        send(1'b0, 5'h07, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);
        chk("pre_rst_prrd", 32'(bif.PrRd), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_prrd", 32'(bif.PrRd), 0);
        chk("mid_rst_prwr", 32'(bif.PrWr), 0);
        chk("mid_rst_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("mid_rst_busy", 32'(bif.busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", 32'(bif.cmd_ready), 1);
        chk("after_rst_busy", 32'(bif.busy), 0);
        repeat (4) @(negedge clk);
        done_at = 1;
        send(1'b0, 5'h03, 8'h00, 1'b1, 8'hA5, 1'b0, 1);
        drain();

        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
